pipe_stage_skid_reg: RTL and testbench

//  Parametrised pipeline stage register. Generalises the fixed ID/EX register: it carries any

---
 rtl/pipe_stage_skid_reg.sv | 140 ++++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - parametrised pipeline stage register with valid/ready, flush and skid buffer
//
// Carries a control bundle (zeroed whenever the stage holds a bubble) and a
// payload bundle (held across bubbles) between two pipeline stages.
// SKID=1 adds a second entry so that in_ready comes straight from a flop.
//
// Ports:
//   clk        clock, rising edge
//   clr        asynchronous active-high reset
//   flush      synchronous kill of every held entry (and of any same-cycle accept)
//   in_valid   upstream entry valid
//   in_ready   stage can accept this cycle
//   in_ctrl    upstream control bundle
//   in_data    upstream payload
//   out_valid  head entry presented downstream
//   out_ready  downstream accepts (0 = stall)
//   out_ctrl   control of head entry, 0 when out_valid=0
//   out_data   payload of head entry
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0

module pipe_stage_skid_reg #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 101,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              acc;
    logic              take;
    logic              in_ready_q;
    logic              load_in_main;
    logic              load_skid_main;
    logic              load_skid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign out_valid = (state != S_EMPTY);
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign take      = out_valid & out_ready;
    assign acc       = in_valid & in_ready;

    // With the skid entry, in_ready is a flop (qualified only by the async
    // reset); without it, the single entry may be refilled in the same cycle
    // it drains, so ready must look at out_ready.
    generate
        if (SKID != 0) begin : g_skid_ready
            assign in_ready = in_ready_q & ~clr;
        end else begin : g_comb_ready
            assign in_ready = ~clr & (~out_valid | out_ready);
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: if (acc) state_nxt = S_ONE;
                S_ONE: begin
                    if (acc && !take)
                        state_nxt = (SKID != 0) ? S_TWO : S_ONE;
                    else if (!acc && take)
                        state_nxt = S_EMPTY;
                end
                S_TWO:   if (take) state_nxt = S_ONE;
                default: state_nxt = S_EMPTY;
            endcase
        end
    end

    // Main register is refilled from the input when it is (or becomes) free,
    // and from the skid entry when the head leaves while two are held.
    assign load_in_main   = !flush && acc && ((state == S_EMPTY) || ((state == S_ONE) && take));
    assign load_skid_main = !flush && (state == S_TWO) && take;
    assign load_skid      = !flush && acc && (state == S_ONE) && !take;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= S_EMPTY;
            in_ready_q <= 1'b1;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
            stall_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != S_TWO);

            // Bubble: control is cleared, payload keeps its last value.
            if (state_nxt == S_EMPTY)
                main_ctrl <= '0;
            else if (load_in_main)
                main_ctrl <= in_ctrl;
            else if (load_skid_main)
                main_ctrl <= skid_ctrl;

            if (load_in_main)
                main_data <= in_data;
            else if (load_skid_main)
                main_data <= skid_data;

            if (flush) begin
                skid_ctrl <= '0;
            end else if (load_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end

            if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - self-checking bench for pipe_stage_skid_reg against a queue model

module tb_pipe_stage_skid_reg;

    localparam int CW  = 9;
    localparam int DW  = 101;
    localparam int CW1 = 4;
    localparam int DW1 = 8;

    logic           clk = 1'b0;
    logic           clr;
    logic           flush;
    logic           in_valid;
    logic           out_ready;
    logic [CW-1:0]  in_ctrl;
    logic [DW-1:0]  in_data;

    logic           in_ready0, out_valid0;
    logic [CW-1:0]  out_ctrl0;
    logic [DW-1:0]  out_data0;
    logic [15:0]    stall_cnt0;

    logic           in_ready1, out_valid1;
    logic [CW1-1:0] out_ctrl1;
    logic [DW1-1:0] out_data1;
    logic [1:0]     stall_cnt1;

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) u0 (
        .clk(clk), .clr(clr), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_data(out_data0),
        .stall_cnt(stall_cnt0)
    );

    pipe_stage_skid_reg #(.CTRL_W(CW1), .DATA_W(DW1), .SKID(0), .CNT_W(2)) u1 (
        .clk(clk), .clr(clr), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl[CW1-1:0]), .in_data(in_data[DW1-1:0]),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1), .out_data(out_data1),
        .stall_cnt(stall_cnt1)
    );

    int total = 0;
    int bad   = 0;

    // Reference: a FIFO of capacity 2 (u0) or 1 (u1), plus the last head payload.
    logic [CW+DW-1:0]   q0[$];
    logic [CW1+DW1-1:0] q1[$];
    logic [DW-1:0]      last0;
    logic [DW1-1:0]     last1;
    int                 sc0, sc1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] rc();
        logic [31:0] t;
        t = $urandom();
        return t[CW-1:0];
    endfunction

    function automatic logic [DW-1:0] rd();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
        sc0   = 0;
        sc1   = 0;
    endtask

    task automatic check_all();
        logic          e_rdy0, e_rdy1;
        logic [CW-1:0] e_c0;
        logic [CW1-1:0] e_c1;
        e_rdy0 = !clr && (q0.size() < 2);
        e_rdy1 = !clr && ((q1.size() == 0) || out_ready);
        e_c0 = '0;
        e_c1 = '0;
        if (q0.size() > 0) e_c0 = q0[0][CW+DW-1:DW];
        if (q1.size() > 0) e_c1 = q1[0][CW1+DW1-1:DW1];
        chk("u0_in_ready",  128'(in_ready0),  128'(e_rdy0));
        chk("u0_out_valid", 128'(out_valid0), 128'(q0.size() > 0));
        chk("u0_out_ctrl",  128'(out_ctrl0),  128'(e_c0));
        chk("u0_out_data",  128'(out_data0),  128'(last0));
        chk("u0_stall_cnt", 128'(stall_cnt0), 128'(sc0));
        chk("u1_in_ready",  128'(in_ready1),  128'(e_rdy1));
        chk("u1_out_valid", 128'(out_valid1), 128'(q1.size() > 0));
        chk("u1_out_ctrl",  128'(out_ctrl1),  128'(e_c1));
        chk("u1_out_data",  128'(out_data1),  128'(last1));
        chk("u1_stall_cnt", 128'(stall_cnt1), 128'(sc1));
    endtask

    task automatic model_update();
        logic a0, t0, a1, t1;
        a0 = in_valid && (q0.size() < 2);
        t0 = (q0.size() > 0) && out_ready;
        a1 = in_valid && ((q1.size() == 0) || out_ready);
        t1 = (q1.size() > 0) && out_ready;
        if ((q0.size() > 0) && !out_ready && (sc0 < 65535)) sc0++;
        if ((q1.size() > 0) && !out_ready && (sc1 < 3)) sc1++;
        if (flush) begin
            q0.delete();
            q1.delete();
        end else begin
            if (t0) void'(q0.pop_front());
            if (a0) q0.push_back({in_ctrl, in_data});
            if (t1) void'(q1.pop_front());
            if (a1) q1.push_back({in_ctrl[CW1-1:0], in_data[DW1-1:0]});
        end
        if (q0.size() > 0) last0 = q0[0][DW-1:0];
        if (q1.size() > 0) last1 = q1[0][DW1-1:0];
    endtask

    // Called at a falling edge: drive, check, advance the model over the next rising edge.
    task automatic step(input logic iv, input logic orr, input logic fl,
                        input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid  = iv;
        out_ready = orr;
        flush     = fl;
        in_ctrl   = c;
        in_data   = d;
        #1;
        check_all();
        model_update();
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle, held over one rising edge.
    task automatic pulse_clr();
        #2;
        clr = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        clr       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        model_reset();
        @(negedge clk);
        check_all();
        clr = 1'b0;

        // 1: streaming 1..8 with downstream always ready
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, rc(), DW'(i));
        step(1'b0, 1'b1, 1'b0, rc(), rd());
        step(1'b0, 1'b1, 1'b0, rc(), rd());

        // 2: stall with two entries held, then release in order
        pulse_clr();
        step(1'b1, 1'b0, 1'b0, 9'h0a5, DW'(101'hA));
        step(1'b1, 1'b0, 1'b0, 9'h15a, DW'(101'hB));
        step(1'b0, 1'b0, 1'b0, rc(), rd());
        step(1'b0, 1'b0, 1'b0, rc(), rd());
        chk("t2_stall_cnt", 128'(stall_cnt0), 128'(3));
        chk("t2_head_a", 128'(out_data0), 128'(101'hA));
        step(1'b0, 1'b1, 1'b0, rc(), rd());
        chk("t2_head_b", 128'(out_data0), 128'(101'hB));
        step(1'b0, 1'b1, 1'b0, rc(), rd());
        step(1'b0, 1'b1, 1'b0, rc(), rd());

        // 3: flush while two held and a new entry offered
        step(1'b1, 1'b0, 1'b0, rc(), rd());
        step(1'b1, 1'b0, 1'b0, rc(), rd());
        step(1'b1, 1'b0, 1'b1, 9'h1ff, DW'(101'hC));
        chk("t3_valid", 128'(out_valid0), 128'(0));
        chk("t3_ctrl",  128'(out_ctrl0),  128'(0));
        step(1'b0, 1'b1, 1'b0, rc(), rd());
        step(1'b0, 1'b1, 1'b0, rc(), rd());

        // 4: async reset while two held, then a fresh entry
        step(1'b1, 1'b0, 1'b0, rc(), rd());
        step(1'b1, 1'b0, 1'b0, rc(), rd());
        pulse_clr();
        step(1'b1, 1'b1, 1'b0, 9'h033, DW'(101'hD));
        chk("t4_first_out", 128'(out_data0), 128'(101'hD));
        step(1'b0, 1'b1, 1'b0, rc(), rd());

        // 5: single-entry instance, ready drops combinationally with out_ready
        step(1'b1, 1'b0, 1'b0, rc(), rd());
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("t5_rdy_low", 128'(in_ready1), 128'(0));
        step(1'b1, 1'b1, 1'b0, 9'h044, DW'(101'h5E));
        step(1'b0, 1'b1, 1'b0, rc(), rd());
        step(1'b0, 1'b1, 1'b0, rc(), rd());

        // 6: 2-bit counter saturates
        pulse_clr();
        step(1'b1, 1'b0, 1'b0, rc(), rd());
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, rc(), rd());
        chk("t6_sat2", 128'(stall_cnt1), 128'(3));
        chk("t6_cnt16", 128'(stall_cnt0), 128'(5));
        step(1'b0, 1'b1, 1'b0, rc(), rd());
        step(1'b0, 1'b1, 1'b0, rc(), rd());

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ((i % 500) == 499) pulse_clr();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, rc(), rd());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
